// File: rtl/slot_pkg.sv
// Shared slot-machine definitions: FSM encoding, default reel size, win levels
// and the small helpers the reel controller and the score/display blocks share.
package slot_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SPIN3  = 3'd1;
    localparam logic [2:0] ST_SPIN2  = 3'd2;
    localparam logic [2:0] ST_SPIN1  = 3'd3;
    localparam logic [2:0] ST_EVAL   = 3'd4;
    localparam logic [2:0] ST_RESULT = 3'd5;

    localparam int SYMBOLS_DEFAULT = 10;

    localparam logic [1:0] WIN_NONE   = 2'd0;
    localparam logic [1:0] WIN_PAIR   = 2'd1;
    localparam logic [1:0] WIN_TRIPLE = 2'd2;

    function automatic logic [1:0] score_reels(input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] c);
        if (a == b && b == c)
            return WIN_TRIPLE;
        else if (a == b || b == c || a == c)
            return WIN_PAIR;
        return WIN_NONE;
    endfunction

    // Fold a 4-bit RNG value into the symbol range with one conditional subtract.
    function automatic logic [3:0] reduce_rand(input logic [3:0] r, input logic [4:0] symbols);
        logic [4:0] r_ext;
        r_ext = {1'b0, r};
        if (r_ext >= symbols)
            return 4'(r_ext - symbols);
        return r;
    endfunction

endpackage

// File: rtl/reel_stop_ctrl_tick_divider.sv
// Animation tick generator: free-runs 0..TICK_DIV-1 while enabled, rests at 0
// otherwise, and restarts from 0 whenever clr is asserted.
module tick_divider #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = en && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= '0;
        else if (!en || clr || tick)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + CW'(1);
    end

endmodule

// File: rtl/reel_stop_ctrl.sv
// Three-reel slot controller: spins reels at the tick rate, freezes them left to
// right on stop presses (or auto-stop timeouts) and scores the final symbols.
module reel_stop_ctrl
    import slot_pkg::*;
#(
    parameter int TICK_DIV  = 2_500_000,
    parameter int SYMBOLS   = SYMBOLS_DEFAULT,
    parameter int AUTO_STOP = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] rand_num,
    output logic       rand_en,
    output logic [3:0] reel0,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic [2:0] spinning,
    output logic [1:0] win_level,
    output logic       done
);

    localparam int AW = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STOP - 1);
    localparam logic [3:0]    SYM_LAST  = 4'(SYMBOLS - 1);
    localparam logic [4:0]    SYM_EXT   = 5'(SYMBOLS);

    logic [2:0]    state_reg, state_next;
    logic [2:0]    spinning_reg;
    logic [AW-1:0] auto_reg;
    logic [1:0]    win_reg;
    logic          done_reg;
    logic          rand_en_reg;

    logic          in_spin, start_evt, eval_now;
    logic [2:0]    freeze_mask;
    logic          tick, auto_stop, stop_evt;
    logic [3:0]    freeze_val;

    assign auto_stop  = tick && (auto_reg == AUTO_LAST);
    assign stop_evt   = in_spin && (stop || auto_stop);
    assign freeze_val = reduce_rand(rand_num, SYM_EXT);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_spin),
        .clr   (stop_evt),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RESULT: if (start) state_next = ST_SPIN3;
            ST_SPIN3:           if (stop_evt) state_next = ST_SPIN2;
            ST_SPIN2:           if (stop_evt) state_next = ST_SPIN1;
            ST_SPIN1:           if (stop_evt) state_next = ST_EVAL;
            ST_EVAL:            state_next = ST_RESULT;
            default:            state_next = ST_IDLE;
        endcase
    end

    // Decode per-state controls; the reel being frozen is always the leftmost spinner.
    always_comb begin
        in_spin     = 1'b0;
        start_evt   = 1'b0;
        eval_now    = 1'b0;
        freeze_mask = 3'b000;
        case (state_reg)
            ST_IDLE, ST_RESULT: start_evt = start;
            ST_SPIN3: begin in_spin = 1'b1; freeze_mask = 3'b001; end
            ST_SPIN2: begin in_spin = 1'b1; freeze_mask = 3'b010; end
            ST_SPIN1: begin in_spin = 1'b1; freeze_mask = 3'b100; end
            ST_EVAL:  eval_now = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spinning_reg <= 3'b000;
            auto_reg     <= '0;
            win_reg      <= WIN_NONE;
            done_reg     <= 1'b0;
            rand_en_reg  <= 1'b0;
        end else begin
            done_reg    <= eval_now;
            rand_en_reg <= (state_next == ST_SPIN3) || (state_next == ST_SPIN2) ||
                           (state_next == ST_SPIN1);
            if (start_evt) begin
                spinning_reg <= 3'b111;
                auto_reg     <= '0;
                win_reg      <= WIN_NONE;
            end else if (stop_evt) begin
                spinning_reg <= spinning_reg & ~freeze_mask;
                auto_reg     <= '0;
            end else if (tick) begin
                auto_reg <= auto_reg + AW'(1);
            end
            if (eval_now)
                win_reg <= score_reels(reel0, reel1, reel2);
        end
    end

    // A freeze beats the animation step on the same edge; other spinners still advance.
    for (genvar gi = 0; gi < 3; gi++) begin : g_reel
        logic [3:0] val_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                val_reg <= '0;
            else if (stop_evt && freeze_mask[gi])
                val_reg <= freeze_val;
            else if (tick && spinning_reg[gi])
                val_reg <= (val_reg == SYM_LAST) ? 4'd0 : val_reg + 4'd1;
        end
    end

    assign reel0     = g_reel[0].val_reg;
    assign reel1     = g_reel[1].val_reg;
    assign reel2     = g_reel[2].val_reg;
    assign spinning  = spinning_reg;
    assign win_level = win_reg;
    assign done      = done_reg;
    assign rand_en   = rand_en_reg;

endmodule

// File: tb/tb_reel_stop_ctrl.sv
// Directed bench for reel_stop_ctrl: a game-level reference model checked every
// cycle, plus hand-computed checkpoints for the scenarios of interest.
module tb_reel_stop_ctrl;

    localparam int TD  = 4;
    localparam int AS  = 3;
    localparam int SYM = 10;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] rand_num;
    logic       rand_en;
    logic [3:0] reel0, reel1, reel2;
    logic [2:0] spinning;
    logic [1:0] win_level;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    bit checking = 0;

    reel_stop_ctrl #(.TICK_DIV(TD), .SYMBOLS(SYM), .AUTO_STOP(AS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .rand_num  (rand_num),
        .rand_en   (rand_en),
        .reel0     (reel0),
        .reel1     (reel1),
        .reel2     (reel2),
        .spinning  (spinning),
        .win_level (win_level),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game-level model: mode 0 parked, 1 spinning, 2 evaluating.
    int m_mode = 0;
    int m_stopped = 0;
    int m_clk_cnt = 0;
    int m_ticks = 0;
    int m_reel [3] = '{0, 0, 0};
    int m_win = 0;
    int m_done = 0;
    int m_distinct;
    bit m_tick, m_press;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_stopped = 0; m_clk_cnt = 0; m_ticks = 0;
            m_reel = '{0, 0, 0}; m_win = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_mode == 2) begin
                m_distinct = 1 + int'(m_reel[1] != m_reel[0]) +
                             int'(m_reel[2] != m_reel[0] && m_reel[2] != m_reel[1]);
                m_win  = 3 - m_distinct;
                m_done = 1;
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1; m_stopped = 0; m_clk_cnt = 0; m_ticks = 0; m_win = 0;
                end
            end else begin
                m_tick  = ((m_clk_cnt + 1) % TD) == 0;
                m_clk_cnt = m_clk_cnt + 1;
                m_press = stop || (m_tick && (m_ticks + 1) == AS);
                for (int i = 0; i < 3; i++) begin
                    if (i >= m_stopped) begin
                        if (m_press && i == m_stopped)
                            m_reel[i] = int'(rand_num) % SYM;
                        else if (m_tick)
                            m_reel[i] = (m_reel[i] + 1) % SYM;
                    end
                end
                if (m_press) begin
                    m_stopped = m_stopped + 1;
                    m_clk_cnt = 0;
                    m_ticks   = 0;
                    if (m_stopped == 3) m_mode = 2;
                end else if (m_tick) begin
                    m_ticks = m_ticks + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking && rst_n) begin
            chk("reel0", int'(reel0), m_reel[0]);
            chk("reel1", int'(reel1), m_reel[1]);
            chk("reel2", int'(reel2), m_reel[2]);
            chk("spinning", int'(spinning), (m_mode == 1) ? ((7 << m_stopped) & 7) : 0);
            chk("rand_en", int'(rand_en), int'(m_mode == 1));
            chk("win_level", int'(win_level), m_win);
            chk("done", int'(done), m_done);
            if (done) done_seen++;
        end
    end

    task automatic step(input logic s, input logic p, input logic [3:0] r);
        @(negedge clk);
        #1;
        start = s; stop = p; rand_num = r;
    endtask

    task automatic idle(input int n, input logic [3:0] r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, r);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reels"}, int'({reel0, reel1, reel2}), 0);
        chk({tag, "_spinning"}, int'(spinning), 0);
        chk({tag, "_rand_en"}, int'(rand_en), 0);
        chk({tag, "_win"}, int'(win_level), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; rand_num = 4'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        #1 rst_n = 1'b1;
        checking = 1'b1;

        // Triple: 7/7/7
        d0 = done_seen;
        step(1, 0, 0); step(0, 0, 0);
        step(0, 1, 7); step(0, 1, 7); step(0, 0, 0); step(0, 1, 7);
        settle();
        chk("a_eval_spinning", int'(spinning), 0);
        chk("a_eval_rand_en", int'(rand_en), 0);
        step(0, 0, 0); settle();
        chk("a_done", int'(done), 1);
        chk("a_win", int'(win_level), 2);
        chk("a_reels", int'({reel0, reel1, reel2}), 'h777);
        step(0, 0, 0); settle();
        chk("a_done_clear", int'(done), 0);
        chk("a_rand_en_low", int'(rand_en), 0);
        chk("a_done_pulses", done_seen - d0, 1);

        // Pair with wrap reduction: 12 -> 2
        step(1, 0, 0); step(0, 1, 12); step(0, 1, 2); step(0, 1, 5); step(0, 0, 0);
        settle();
        chk("b_reels", int'({reel0, reel1, reel2}), 'h225);
        chk("b_win", int'(win_level), 1);
        chk("b_done", int'(done), 1);

        // Reset while two reels still spin
        step(1, 0, 0); step(0, 1, 3);
        d0 = done_seen;
        step(0, 0, 0); step(0, 0, 0);
        settle();
        chk("r_spinning_pre", int'(spinning), 3'b110);
        @(negedge clk); #1 rst_n = 1'b0;
        settle();
        chk_all_zero("mid_reset");
        @(negedge clk); #1 rst_n = 1'b1;
        chk("r_no_done", done_seen - d0, 0);

        // Animation from reset: tick every 4th clock, auto-stop on 3rd tick
        step(1, 0, 4); idle(3, 4); settle();
        chk("c_reel0_t0", int'(reel0), 0);
        idle(1, 4); settle();
        chk("c_reel0_t1", int'(reel0), 1);
        idle(4, 4); settle();
        chk("c_reel0_t2", int'(reel0), 2);
        step(0, 0, 1); step(0, 0, 2); step(0, 0, 3); step(0, 0, 13); settle();
        chk("c_auto_reel0", int'(reel0), 3);
        chk("c_auto_reel1", int'(reel1), 3);
        chk("c_auto_spinning", int'(spinning), 3'b110);

        // Stop on the same edge as a tick
        idle(3, 0); step(0, 1, 11); settle();
        chk("d_frozen_reel1", int'(reel1), 1);
        chk("d_stepped_reel2", int'(reel2), 4);
        chk("d_spinning", int'(spinning), 3'b100);

        // Start during SPIN1 is ignored
        step(1, 0, 0); settle();
        chk("e_spinning", int'(spinning), 3'b100);
        chk("e_rand_en", int'(rand_en), 1);
        step(0, 1, 8); settle();
        chk("e_eval_spinning", int'(spinning), 0);
        step(0, 0, 0); settle();
        chk("e_done", int'(done), 1);
        chk("e_win_none", int'(win_level), 0);

        // Start+stop in RESULT: new game; then reel2 wraps 9 -> 0
        step(1, 1, 6); settle();
        chk("f_spinning", int'(spinning), 3'b111);
        chk("f_reel0_kept", int'(reel0), 3);
        d0 = done_seen;
        idle(4, 0); settle();
        chk("f_reel2_9", int'(reel2), 9);
        chk("f_reel0_4", int'(reel0), 4);
        idle(4, 0); settle();
        chk("f_reel2_wrap", int'(reel2), 0);
        idle(40, 5); step(0, 0, 5); settle();
        chk("f_auto_reels", int'({reel0, reel1, reel2}), 'h555);
        chk("f_auto_win", int'(win_level), 2);
        chk("f_done_pulses", done_seen - d0, 1);

        idle(2, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
